wb_commit_arbiter: RTL and testbench

Shares the single register-file commit port among NUM_UNITS writeback-capable execution units using round-robin arbitration. It sits between the unit writeback interfaces (wb_packet_t-style id/valid/data) and the register file. It translates each winning instruction id to its physical destination register via an id-indexed table filled at issue. The output is a registered commit_packet_t.

---
 rtl/wb_commit_arbiter_pkg.sv | 19 +
 rtl/wb_commit_arbiter_rr_priority_select.sv | 38 +++
 rtl/wb_commit_arbiter.sv | 97 +++++++++
 tb/tb_wb_commit_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_commit_arbiter_pkg.sv
// Shared types and sizing for the writeback commit arbiter slice.
// Mirrors the id/physical-register/commit types used by the surrounding core.
package wb_commit_arbiter_pkg;

    localparam int unsigned MAX_IDS               = 8;
    localparam int unsigned LOG2_MAX_IDS          = $clog2(MAX_IDS);
    localparam int unsigned MAX_POSSIBLE_REG_BITS = 32;

    typedef logic [LOG2_MAX_IDS-1:0] id_t;
    typedef logic [5:0]              phys_addr_t;

    typedef struct packed {
        logic                             valid;
        id_t                              id;
        phys_addr_t                       phys_addr;
        logic [MAX_POSSIBLE_REG_BITS-1:0] data;
    } commit_packet_t;

endpackage

// File: rtl/wb_commit_arbiter_rr_priority_select.sv
// Round-robin priority select: first asserted request at or after ptr, wrapping.
// Generic over N so other shared-resource arbiters can reuse it.
module rr_priority_select #(
    parameter int unsigned N = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  requests,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid
);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        sum         = '0;
        idx         = '0;
        for (int unsigned i = 0; i < N; i++) begin
            // ptr < N and i < N, so one conditional subtract performs the wrap
            sum = {1'b0, ptr} + (IW+1)'(i);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            idx = sum[IW-1:0];
            if (!grant_valid && requests[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
                grant[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_commit_arbiter.sv
// Round-robin arbitration of unit writebacks onto the single register-file
// commit port, translating winning ids to physical registers via the issue table.
module wb_commit_arbiter
    import wb_commit_arbiter_pkg::*;
#(
    parameter int unsigned NUM_UNITS  = 4,
    parameter int unsigned DATA_WIDTH = MAX_POSSIBLE_REG_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  id_t                   issue_id,
    input  phys_addr_t            issue_phys_addr,
    input  logic                  issue_uses_rd,
    input  logic [NUM_UNITS-1:0]  unit_valid,
    input  id_t                   unit_id   [NUM_UNITS],
    input  logic [DATA_WIDTH-1:0] unit_data [NUM_UNITS],
    output logic [NUM_UNITS-1:0]  unit_ack,
    input  logic                  writeback_suppress,
    output commit_packet_t        commit,
    output logic                  wb_conflict
);

    localparam int unsigned PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    phys_addr_t tbl_phys    [MAX_IDS];
    logic       tbl_uses_rd [MAX_IDS];

    logic [MAX_IDS-1:0] pending_q, pending_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    commit_packet_t     commit_q, commit_d;
    logic               conflict_q, conflict_d;

    logic [NUM_UNITS-1:0] requests;
    logic [PTR_W-1:0]     grant_idx;
    logic                 grant_valid;
    id_t                  win_id;

    assign requests = unit_valid & {NUM_UNITS{~writeback_suppress}};

    rr_priority_select #(.N(NUM_UNITS)) u_select (
        .requests    (requests),
        .ptr         (rr_ptr_q),
        .grant       (unit_ack),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign win_id = unit_id[grant_idx];

    // Table payload has no reset so it can map onto distributed RAM
    always_ff @(posedge clk) begin
        if (issue_valid) begin
            tbl_phys[issue_id]    <= issue_phys_addr;
            tbl_uses_rd[issue_id] <= issue_uses_rd;
        end
    end

    always_comb begin
        pending_d      = pending_q;
        rr_ptr_d       = rr_ptr_q;
        commit_d       = commit_q;
        commit_d.valid = 1'b0;
        conflict_d     = ($countones(unit_valid) > 1) && !writeback_suppress;

        if (grant_valid) begin
            commit_d.valid     = tbl_uses_rd[win_id] & pending_q[win_id];
            commit_d.id        = win_id;
            commit_d.phys_addr = tbl_phys[win_id];
            commit_d.data      = MAX_POSSIBLE_REG_BITS'(unit_data[grant_idx]);
            pending_d[win_id]  = 1'b0;
            rr_ptr_d = (grant_idx == PTR_W'(NUM_UNITS - 1)) ? '0 : grant_idx + 1'b1;
        end
        // Issue after writeback clear: a same-id collision is illegal anyway
        if (issue_valid) begin
            pending_d[issue_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q  <= '0;
            rr_ptr_q   <= '0;
            commit_q   <= '0;
            conflict_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            rr_ptr_q   <= rr_ptr_d;
            commit_q   <= commit_d;
            conflict_q <= conflict_d;
        end
    end

    assign commit      = commit_q;
    assign wb_conflict = conflict_q;

endmodule

// File: tb/tb_wb_commit_arbiter.sv
// Directed bench for wb_commit_arbiter: arbitration order, commit contents,
// suppression and asynchronous reset behaviour against hand-computed values.
module tb_wb_commit_arbiter;
    import wb_commit_arbiter_pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    logic           issue_valid;
    id_t            issue_id;
    phys_addr_t     issue_phys_addr;
    logic           issue_uses_rd;
    logic [3:0]     unit_valid;
    id_t            unit_id   [4];
    logic [31:0]    unit_data [4];
    logic [3:0]     unit_ack;
    logic           writeback_suppress;
    commit_packet_t commit;
    logic           wb_conflict;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    wb_commit_arbiter #(.NUM_UNITS(4), .DATA_WIDTH(32)) dut (
        .clk                (clk),
        .rst                (rst),
        .issue_valid        (issue_valid),
        .issue_id           (issue_id),
        .issue_phys_addr    (issue_phys_addr),
        .issue_uses_rd      (issue_uses_rd),
        .unit_valid         (unit_valid),
        .unit_id            (unit_id),
        .unit_data          (unit_data),
        .unit_ack           (unit_ack),
        .writeback_suppress (writeback_suppress),
        .commit             (commit),
        .wb_conflict        (wb_conflict)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_commit(input string tag, input logic v, input logic [63:0] id,
                              input logic [63:0] phys, input logic [63:0] data);
        chk({tag, ".valid"}, 64'(commit.valid), 64'(v));
        chk({tag, ".id"},    64'(commit.id), id);
        chk({tag, ".phys"},  64'(commit.phys_addr), phys);
        chk({tag, ".data"},  64'(commit.data), data);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_issue(input logic [63:0] id, input logic [63:0] phys, input logic uses);
        issue_valid     = 1'b1;
        issue_id        = id_t'(id);
        issue_phys_addr = phys_addr_t'(phys);
        issue_uses_rd   = uses;
        cyc();
        issue_valid     = 1'b0;
    endtask

    task automatic set_unit(input int u, input logic [63:0] id, input logic [31:0] data);
        unit_id[u]   = id_t'(id);
        unit_data[u] = data;
    endtask

    initial begin
        rst                = 1'b1;
        issue_valid        = 1'b0;
        issue_id           = '0;
        issue_phys_addr    = '0;
        issue_uses_rd      = 1'b0;
        unit_valid         = '0;
        writeback_suppress = 1'b0;
        for (int i = 0; i < 4; i++) begin
            unit_id[i]   = '0;
            unit_data[i] = '0;
        end

        // Reset state
        #2;
        chk("reset.commit", 64'(commit), 64'h0);
        chk("reset.conflict", 64'(wb_conflict), 64'h0);
        chk("reset.ack", 64'(unit_ack), 64'h0);
        #1 rst = 1'b0;
        cyc();

        // Single request
        do_issue(3, 'h15, 1'b1);
        set_unit(1, 3, 32'hDEADBEEF);
        unit_valid = 4'b0010;
        #1 chk("single.ack", 64'(unit_ack), 64'h2);
        cyc();
        unit_valid = 4'b0000;
        chk_commit("single", 1'b1, 3, 'h15, 'hDEADBEEF);
        chk("single.conflict", 64'(wb_conflict), 64'h0);
        chk("single.pending3", 64'(dut.pending_q[3]), 64'h0);
        cyc();
        chk_commit("idle_hold", 1'b0, 3, 'h15, 'hDEADBEEF);

        // Move rr_ptr from 2 to 0 via a lone grant to unit 3 (id 6, no rd)
        do_issue(6, 'h06, 1'b0);
        set_unit(3, 6, 32'h66);
        unit_valid = 4'b1000;
        #1 chk("setup.ack", 64'(unit_ack), 64'h8);
        cyc();
        unit_valid = 4'b0000;
        chk("setup.valid", 64'(commit.valid), 64'h0);

        // Fairness: all four request continuously, same ids held
        do_issue(0, 'h20, 1'b1);
        do_issue(1, 'h21, 1'b1);
        do_issue(2, 'h22, 1'b1);
        do_issue(4, 'h24, 1'b1);
        set_unit(0, 0, 32'hA0);
        set_unit(1, 1, 32'hA1);
        set_unit(2, 2, 32'hA2);
        set_unit(3, 4, 32'hA3);
        unit_valid = 4'b1111;
        #1 chk("fair0.ack", 64'(unit_ack), 64'h1);
        cyc();
        chk_commit("fair0", 1'b1, 0, 'h20, 'hA0);
        chk("fair0.conflict", 64'(wb_conflict), 64'h1);
        #1 chk("fair1.ack", 64'(unit_ack), 64'h2);
        cyc();
        chk_commit("fair1", 1'b1, 1, 'h21, 'hA1);
        chk("fair1.conflict", 64'(wb_conflict), 64'h1);
        #1 chk("fair2.ack", 64'(unit_ack), 64'h4);
        cyc();
        chk_commit("fair2", 1'b1, 2, 'h22, 'hA2);
        chk("fair2.conflict", 64'(wb_conflict), 64'h1);
        #1 chk("fair3.ack", 64'(unit_ack), 64'h8);
        cyc();
        chk_commit("fair3", 1'b1, 4, 'h24, 'hA3);
        chk("fair3.conflict", 64'(wb_conflict), 64'h1);
        #1 chk("fair4.ack", 64'(unit_ack), 64'h1);
        cyc();
        unit_valid = 4'b0000;
        // id 0 was already consumed, so this repeat writeback does not commit
        chk_commit("fair4", 1'b0, 0, 'h20, 'hA0);
        chk("fair4.conflict", 64'(wb_conflict), 64'h1);

        // No-rd drop (rr_ptr = 1)
        do_issue(5, 'h2A, 1'b0);
        set_unit(1, 5, 32'h55);
        unit_valid = 4'b0010;
        #1 chk("nord.ack", 64'(unit_ack), 64'h2);
        cyc();
        unit_valid = 4'b0000;
        chk("nord.valid", 64'(commit.valid), 64'h0);
        chk("nord.id", 64'(commit.id), 64'h5);
        chk("nord.pending5", 64'(dut.pending_q[5]), 64'h0);

        // Wrap and skip: get rr_ptr to 3 via unit 2 (rr_ptr = 2 now)
        do_issue(7, 'h07, 1'b1);
        do_issue(0, 'h30, 1'b1);
        do_issue(2, 'h32, 1'b1);
        set_unit(2, 7, 32'h77);
        unit_valid = 4'b0100;
        #1 chk("wrapset.ack", 64'(unit_ack), 64'h4);
        cyc();
        chk_commit("wrapset", 1'b1, 7, 'h07, 'h77);
        set_unit(0, 0, 32'hB0);
        set_unit(2, 2, 32'hB2);
        unit_valid = 4'b0101;
        #1 chk("wrap.ack", 64'(unit_ack), 64'h1);
        cyc();
        chk_commit("wrap", 1'b1, 0, 'h30, 'hB0);
        chk("wrap.conflict", 64'(wb_conflict), 64'h1);
        unit_valid = 4'b0100;
        #1 chk("skip.ack", 64'(unit_ack), 64'h4);
        cyc();
        unit_valid = 4'b0000;
        chk_commit("skip", 1'b1, 2, 'h32, 'hB2);
        chk("skip.conflict", 64'(wb_conflict), 64'h0);

        // Suppress with rr_ptr = 3; units 3 and 0 both requesting
        do_issue(4, 'h14, 1'b1);
        do_issue(1, 'h11, 1'b1);
        set_unit(3, 4, 32'hC3);
        set_unit(0, 1, 32'hC0);
        writeback_suppress = 1'b1;
        unit_valid = 4'b1001;
        for (int c = 0; c < 2; c++) begin
            #1 chk("supp.ack", 64'(unit_ack), 64'h0);
            cyc();
            chk("supp.valid", 64'(commit.valid), 64'h0);
            chk("supp.conflict", 64'(wb_conflict), 64'h0);
        end
        writeback_suppress = 1'b0;
        #1 chk("release.ack", 64'(unit_ack), 64'h8);
        cyc();
        chk_commit("release", 1'b1, 4, 'h14, 'hC3);
        chk("release.conflict", 64'(wb_conflict), 64'h1);
        unit_valid = 4'b0001;
        #1 chk("after.ack", 64'(unit_ack), 64'h1);
        cyc();
        unit_valid = 4'b0000;
        chk_commit("after", 1'b1, 1, 'h11, 'hC0);

        // Async reset between grant and commit (rr_ptr = 1); id 3 left pending
        do_issue(3, 'h03, 1'b1);
        do_issue(6, 'h06, 1'b1);
        set_unit(2, 6, 32'hD2);
        unit_valid = 4'b0100;
        #1 chk("rstg.ack", 64'(unit_ack), 64'h4);
        cyc();
        unit_valid = 4'b0000;
        chk("rstg.valid", 64'(commit.valid), 64'h1);
        rst = 1'b1;
        #1 chk("rst.commit", 64'(commit), 64'h0);
        chk("rst.conflict", 64'(wb_conflict), 64'h0);
        cyc();
        chk("rst.hold", 64'(commit.valid), 64'h0);
        rst = 1'b0;
        cyc();
        chk("postrst.valid", 64'(commit.valid), 64'h0);
        do_issue(2, 'h22, 1'b1);
        set_unit(1, 2, 32'hE1);
        set_unit(2, 7, 32'hE2);
        unit_valid = 4'b0110;
        #1 chk("postrst.ack", 64'(unit_ack), 64'h2);
        cyc();
        chk_commit("postrst", 1'b1, 2, 'h22, 'hE1);
        unit_valid = 4'b0000;
        // Pending bit for id 3 was cleared by reset, so its writeback is not committed
        set_unit(0, 3, 32'hF0);
        unit_valid = 4'b0001;
        #1 chk("stale.ack", 64'(unit_ack), 64'h1);
        cyc();
        unit_valid = 4'b0000;
        chk("stale.valid", 64'(commit.valid), 64'h0);
        chk("stale.id", 64'(commit.id), 64'h3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
